// File: rtl/byte_scan_buffer.sv
// Byte widening buffer (256 x 32) with early-exit linear key search.
// Latency: write 1 cycle; scan done_o at k+2 (match at k), N+1 (no match), 1 (empty).
// Backpressure: ready_o low outside IDLE, when full, or while scan_start_i/clear_i asserted.
module byte_scan_buffer #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [7:0]    data_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic          ext_mode_i,
    input  logic          clear_i,
    input  logic          scan_start_i,
    input  logic [31:0]   key_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          found_o,
    output logic [AW-1:0] index_o,
    output logic [AW:0]   count_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = '0;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Entries are never reset; only the pointer/count say what is valid.
    logic [31:0] mem [0:DEPTH-1];

    state_t        state_q,    state_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW:0]   count_q,    count_d;
    logic [AW-1:0] scan_idx_q, scan_idx_d;
    logic [AW:0]   limit_q,    limit_d;
    logic [31:0]   key_q,      key_d;
    logic          found_q,    found_d;
    logic [AW-1:0] index_q,    index_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;

    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic          scan_hit;
    logic          scan_last;

    // Accept a byte only when idle, not full, and no higher-priority command is present.
    assign ready_o = (state_q == S_IDLE) && (count_q != FULL_CNT) && !scan_start_i && !clear_i;

    assign mem_wdata = {{24{ext_mode_i & data_i[7]}}, data_i};
    assign scan_hit  = (mem[scan_idx_q] == key_q);
    assign scan_last = ({1'b0, scan_idx_q} == (limit_q - CNT_ONE));

    // Next-state, write-enable and result logic; priority in IDLE is clear > scan > write.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        scan_idx_d = scan_idx_q;
        limit_d    = limit_q;
        key_d      = key_q;
        found_d    = found_q;
        index_d    = index_q;
        busy_d     = busy_q;
        mem_we     = 1'b0;
        // done_o trails the DONE state by one cycle so it never overlaps busy_o.
        done_d     = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (clear_i) begin
                    wr_ptr_d = '0;
                    count_d  = CNT_ZERO;
                end else if (scan_start_i) begin
                    found_d = 1'b0;
                    index_d = '0;
                    if (count_q != CNT_ZERO) begin
                        key_d      = key_i;
                        limit_d    = count_q;
                        scan_idx_d = '0;
                        busy_d     = 1'b1;
                        state_d    = S_SCAN;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (valid_i && ready_o) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    count_d  = count_q + CNT_ONE;
                end
            end
            S_SCAN: begin
                if (scan_hit) begin
                    found_d = 1'b1;
                    index_d = scan_idx_q;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else if (scan_last) begin
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    scan_idx_d = scan_idx_q + PTR_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control and result registers; reset aborts any scan without a done pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            scan_idx_q <= '0;
            limit_q    <= '0;
            key_q      <= '0;
            found_q    <= 1'b0;
            index_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            scan_idx_q <= scan_idx_d;
            limit_q    <= limit_d;
            key_q      <= key_d;
            found_q    <= found_d;
            index_q    <= index_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Buffer storage write port.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= mem_wdata;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign found_o = found_q;
    assign index_o = index_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_byte_scan_buffer.sv
module tb_byte_scan_buffer;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [7:0]    data_i;
    logic          valid_i;
    logic          ready_o;
    logic          ext_mode_i;
    logic          clear_i;
    logic          scan_start_i;
    logic [31:0]   key_i;
    logic          busy_o;
    logic          done_o;
    logic          found_o;
    logic [AW-1:0] index_o;
    logic [AW:0]   count_o;

    byte_scan_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .ext_mode_i   (ext_mode_i),
        .clear_i      (clear_i),
        .scan_start_i (scan_start_i),
        .key_i        (key_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .found_o      (found_o),
        .index_o      (index_o),
        .count_o      (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       found;
        logic [7:0] idx;
        int         done_cyc;
        int         busy;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          busy_cnt = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] widen(input logic [7:0] b, input logic sext);
        logic [31:0] v;
        v = {24'h0, b};
        if (sext && b >= 8'd128) v = v + 32'hFFFF_FF00;
        return v;
    endfunction

    // Monitor: pop one expectation per done pulse and compare the result.
    always @(negedge clk_i) begin
        if (rst_i) begin
            busy_cnt = 0;
        end else begin
            if (busy_o) busy_cnt++;
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", done_o, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("found", found_o, e.found);
                    chk("index", index_o, e.idx);
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("busy_cycles", busy_cnt, e.busy);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_scan();
        for (int i = 0; i < 600; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk_i); #1;
        end
        if (exp_q.size() != 0) begin
            chk("scan_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic write_byte(input logic [7:0] b, input logic sext);
        valid_i = 1'b1; data_i = b; ext_mode_i = sext;
        #1 chk("ready_on_write", ready_o, model_mem.size() != DEPTH);
        if (model_mem.size() < DEPTH) model_mem.push_back(widen(b, sext));
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        @(posedge clk_i); #1;
        clear_i = 1'b0;
        model_mem.delete();
        chk("count_after_clear", count_o, 0);
    endtask

    task automatic do_scan(input logic [31:0] key, input logic with_valid, input logic with_clear);
        exp_t e;
        int   k;
        int   start;
        int   n_before;
        k = -1;
        foreach (model_mem[i]) if (k < 0 && model_mem[i] == key) k = i;
        n_before = model_mem.size();
        scan_start_i = 1'b1; key_i = key;
        valid_i = with_valid; data_i = 8'($urandom);
        #1 chk("ready_at_scan_start", ready_o, 1'b0);
        start = cyc + 1;
        e.found = 1'b0; e.idx = 8'd0; e.busy = 0;
        if (n_before == 0) begin
            e.done_cyc = start + 1;
        end else if (k >= 0) begin
            e.found = 1'b1; e.idx = k[7:0];
            e.done_cyc = start + k + 2; e.busy = k + 1;
        end else begin
            e.done_cyc = start + n_before + 1; e.busy = n_before;
        end
        exp_q.push_back(e);
        @(posedge clk_i); #1;
        scan_start_i = 1'b0; valid_i = 1'b0;
        if (with_clear) begin
            clear_i = 1'b1;
            @(posedge clk_i); #1;
            @(posedge clk_i); #1;
            clear_i = 1'b0;
        end
        wait_scan();
        chk("count_after_scan", count_o, n_before);
    endtask

    initial begin
        logic [31:0] key;
        int          n;
        rst_i = 1'b1; data_i = '0; valid_i = 1'b0; ext_mode_i = 1'b0;
        clear_i = 1'b0; scan_start_i = 1'b0; key_i = '0;
        #2;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_found", found_o, 0);
        chk("rst_index", index_o, 0);
        chk("rst_count", count_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        #1 chk("rst_ready", ready_o, 1);

        // Sign vs zero extension of the same byte.
        write_byte(8'h85, 1'b1);
        write_byte(8'h85, 1'b0);
        chk("count_two", count_o, 2);
        do_scan(32'hFFFF_FF85, 1'b0, 1'b0);
        do_scan(32'h0000_0085, 1'b0, 1'b0);

        // Early exit, no match, empty buffer.
        do_clear();
        for (int i = 0; i < 8; i++) write_byte(8'(i), 1'b0);
        do_scan(32'd4, 1'b0, 1'b0);
        do_scan(32'h100, 1'b0, 1'b0);
        do_clear();
        do_scan(32'd0, 1'b0, 1'b0);

        // Full buffer with duplicates; the extra byte is dropped.
        for (int i = 0; i < DEPTH; i++) write_byte(8'h11, 1'($urandom));
        chk("count_full", count_o, DEPTH);
        chk("ready_full", ready_o, 0);
        write_byte(8'h22, 1'b0);
        chk("count_still_full", count_o, DEPTH);
        do_scan(32'h11, 1'b0, 1'b0);
        do_scan(32'h22, 1'b0, 1'b0);

        // All three commands together: clear wins, nothing else happens.
        valid_i = 1'b1; scan_start_i = 1'b1; clear_i = 1'b1; data_i = 8'h5A; key_i = 32'h11;
        #1 chk("ready_all_three", ready_o, 0);
        @(posedge clk_i); #1;
        valid_i = 1'b0; scan_start_i = 1'b0; clear_i = 1'b0;
        model_mem.delete();
        chk("count_after_triple", count_o, 0);
        repeat (4) @(posedge clk_i);
        #1;

        // Byte offered alongside scan start is not taken; clear during scan is ignored.
        for (int i = 0; i < 12; i++) write_byte(8'($urandom), 1'($urandom));
        do_scan(model_mem[7], 1'b1, 1'b0);
        do_scan(32'h1234_5678, 1'b0, 1'b1);
        do_scan(model_mem[3], 1'b0, 1'b1);

        // Randomized traffic against the queue model.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 4) == 0) do_clear();
            n = $urandom_range(0, 14);
            for (int j = 0; j < n; j++) write_byte(8'($urandom), 1'($urandom));
            chk("count_random", count_o, model_mem.size());
            if (model_mem.size() > 0 && $urandom_range(0, 2) != 0)
                key = model_mem[$urandom_range(0, model_mem.size() - 1)];
            else if ($urandom_range(0, 1) == 0)
                key = widen(8'($urandom), 1'($urandom));
            else
                key = $urandom;
            do_scan(key, 1'($urandom), 1'b0);
        end

        // Reset in the middle of a long no-match scan.
        do_clear();
        for (int i = 0; i < 200; i++) write_byte(8'($urandom), 1'($urandom));
        scan_start_i = 1'b1; key_i = 32'h1234_5678;
        @(posedge clk_i); #1;
        scan_start_i = 1'b0;
        repeat (49) @(posedge clk_i);
        #3 rst_i = 1'b1;
        #1;
        chk("midscan_busy", busy_o, 0);
        chk("midscan_done", done_o, 0);
        chk("midscan_count", count_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        model_mem.delete();
        #1 chk("ready_after_reset", ready_o, 1);
        chk("count_after_reset", count_o, 0);
        repeat (20) @(posedge clk_i);
        #1;
        do_scan(32'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
